// File: rtl/lut_mult_pkg.sv
// Shared definitions for the LUT-based sequential multiplier.
//   state_t   : FSM state encoding (IDLE, RUN, DONE)
//   DIGIT_W   : operand digit width fed to the 2x2 LUT
//   shift_amt : bit position of a digit product for digit indices i, j
package lut_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DIGIT_W = 2;

   // Digit i of a times digit j of b carries weight 4^(i+j).
   function automatic int unsigned shift_amt(input int unsigned i, input int unsigned j);
      return DIGIT_W * (i + j);
   endfunction

endpackage

// File: rtl/mult2x2_lut.sv
// Combinational 2-bit x 2-bit unsigned multiplier as a full truth table.
//   a : multiplicand digit (2 bits)
//   b : multiplier digit (2 bits)
//   z : product (4 bits, max 9)
module mult2x2_lut (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] z
);

   always_comb begin
      z = 4'd0;
      case ({a, b})
         4'b01_01: z = 4'd1;
         4'b01_10: z = 4'd2;
         4'b01_11: z = 4'd3;
         4'b10_01: z = 4'd2;
         4'b10_10: z = 4'd4;
         4'b10_11: z = 4'd6;
         4'b11_01: z = 4'd3;
         4'b11_10: z = 4'd6;
         4'b11_11: z = 4'd9;
         default:  z = 4'd0;
      endcase
   end

endmodule

// File: rtl/lut_mult_sequencer.sv
// Sequential WIDTH x WIDTH unsigned multiplier. Both operands are split into
// 2-bit digits; one shared 2x2 LUT multiplies one digit pair per cycle and the
// shifted partial products are summed into a 2*WIDTH accumulator. A result
// takes exactly (WIDTH/2)^2 cycles regardless of operand values.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake (in_a, in_b latched on accept)
//   out_valid/out_ready  : result handshake (out_z held while stalled)
//   out_z                : product, updated only when a result completes
//   busy                 : high while an operation is in RUN or DONE
module lut_mult_sequencer
   import lut_mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_z,
   output logic                 busy
);

   localparam int N     = WIDTH / 2;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int ACC_W = 2 * WIDTH;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   state_t             state;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [ACC_W-1:0]   acc;
   logic [IDX_W-1:0]   i_idx;
   logic [IDX_W-1:0]   j_idx;

   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [1:0]         a_dig;
   logic [1:0]         b_dig;
   logic [3:0]         p;
   logic [ACC_W-1:0]   p_sh;
   logic [ACC_W-1:0]   acc_nxt;
   logic               last_pair;

   // Digit selection and shifted partial product for the current (i, j)
   always_comb begin
      a_sh      = a_reg >> shift_amt(32'(i_idx), 32'd0);
      b_sh      = b_reg >> shift_amt(32'(j_idx), 32'd0);
      a_dig     = a_sh[1:0];
      b_dig     = b_sh[1:0];
      p_sh      = ACC_W'(p) << shift_amt(32'(i_idx), 32'(j_idx));
      acc_nxt   = acc + p_sh;
      last_pair = (i_idx == LAST) && (j_idx == LAST);
   end

   mult2x2_lut u_lut (
      .a (a_dig),
      .b (b_dig),
      .z (p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_z     <= '0;
         busy      <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         acc       <= '0;
         i_idx     <= '0;
         j_idx     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg    <= in_a;
                  b_reg    <= in_b;
                  acc      <= '0;
                  i_idx    <= '0;
                  j_idx    <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               acc <= acc_nxt;
               // j is the inner loop; i advances when j wraps
               if (j_idx == LAST) begin
                  j_idx <= '0;
                  i_idx <= i_idx + 1'b1;
               end else begin
                  j_idx <= j_idx + 1'b1;
               end
               if (last_pair) begin
                  // Final sum goes straight to out_z so it is valid with out_valid
                  i_idx     <= '0;
                  out_z     <= acc_nxt;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lut_mult_sequencer.sv
// Scoreboard bench for lut_mult_sequencer at WIDTH = 2, 4 and 8. Expected
// products are pushed when operands are accepted; a monitor pops and compares
// whenever a DUT completes an output handshake.
module tb_lut_mult_sequencer;

   logic clk;
   logic rst_n;

   // Index 0: WIDTH=2, 1: WIDTH=4, 2: WIDTH=8
   logic       iv   [3];
   logic       ordy [3];
   logic [7:0] ia   [3];
   logic [7:0] ib   [3];

   logic        ir2, ov2, bz2;
   logic [3:0]  oz2;
   logic        ir4, ov4, bz4;
   logic [7:0]  oz4;
   logic        ir8, ov8, bz8;
   logic [15:0] oz8;

   typedef struct {
      int          k;
      logic [15:0] z;
   } exp_t;

   exp_t q[$];
   int   total;
   int   bad;
   logic rnd_en;

   lut_mult_sequencer #(.WIDTH(2)) u_w2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[0]), .in_ready(ir2), .in_a(ia[0][1:0]), .in_b(ib[0][1:0]),
      .out_valid(ov2), .out_ready(ordy[0]), .out_z(oz2), .busy(bz2)
   );

   lut_mult_sequencer #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[1]), .in_ready(ir4), .in_a(ia[1][3:0]), .in_b(ib[1][3:0]),
      .out_valid(ov4), .out_ready(ordy[1]), .out_z(oz4), .busy(bz4)
   );

   lut_mult_sequencer #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[2]), .in_ready(ir8), .in_a(ia[2]), .in_b(ib[2]),
      .out_valid(ov8), .out_ready(ordy[2]), .out_z(oz8), .busy(bz8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic f_ov(input int k);
      case (k)
         0:       return ov2;
         1:       return ov4;
         default: return ov8;
      endcase
   endfunction

   function automatic logic f_ir(input int k);
      case (k)
         0:       return ir2;
         1:       return ir4;
         default: return ir8;
      endcase
   endfunction

   function automatic logic f_busy(input int k);
      case (k)
         0:       return bz2;
         1:       return bz4;
         default: return bz8;
      endcase
   endfunction

   function automatic logic [15:0] f_oz(input int k);
      case (k)
         0:       return 16'(oz2);
         1:       return 16'(oz4);
         default: return oz8;
      endcase
   endfunction

   // Number of RUN cycles: (WIDTH/2)^2
   function automatic int nn(input int k);
      case (k)
         0:       return 1;
         1:       return 4;
         default: return 16;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: a result is consumed on any edge where valid & ready
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 3; k++) begin
            if (f_ov(k) && ordy[k]) begin
               if (q.size() == 0) begin
                  chk("unexpected_result", 32'(k), 32'hDEAD);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  chk("result_instance", 32'(k), 32'(e.k));
                  chk("result_value", 32'(f_oz(k)), 32'(e.z));
               end
            end
         end
      end
   end

   // Random output backpressure for the exhaustive WIDTH=4 run
   always @(posedge clk) begin
      if (rnd_en) begin
         #1;
         ordy[1] = 1'($urandom_range(0, 1));
      end
   end

   // Present operands until accepted; optionally push expected and check latency.
   // Called and returns at 1 time unit after a rising edge.
   task automatic send(input int k, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] z, input bit push, input bit lat_chk);
      logic acc_ok;
      int   lat;
      acc_ok = 1'b0;
      iv[k]  = 1'b1;
      ia[k]  = a;
      ib[k]  = b;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         acc_ok = f_ir(k);
         @(posedge clk);
         #1;
         if (acc_ok) break;
      end
      iv[k] = 1'b0;
      if (!acc_ok) begin
         chk("accept_timeout", 32'd0, 32'd1);
      end else begin
         if (push) q.push_back('{k: k, z: z});
         if (lat_chk) begin
            lat = 0;
            for (int c = 1; c <= 200; c++) begin
               @(posedge clk);
               #1;
               if (f_ov(k)) begin
                  lat = c;
                  break;
               end
            end
            chk("latency", 32'(lat), 32'(nn(k)));
         end
      end
   endtask

   task automatic drain(input int limit);
      for (int c = 0; c < limit && q.size() != 0; c++) @(posedge clk);
      #1;
      chk("drain", 32'(q.size()), 32'd0);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      rnd_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         iv[k]   = 1'b0;
         ordy[k] = 1'b1;
         ia[k]   = 8'h00;
         ib[k]   = 8'h00;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("reset_in_ready", 32'(f_ir(k)), 32'd1);
         chk("reset_out_valid", 32'(f_ov(k)), 32'd0);
         chk("reset_out_z", 32'(f_oz(k)), 32'd0);
         chk("reset_busy", 32'(f_busy(k)), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // WIDTH=2: 3*3 after one RUN cycle, ready again one cycle later
      send(0, 8'd3, 8'd3, 16'd9, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      chk("w2_in_ready_back", 32'(ir2), 32'd1);

      // WIDTH=8: zero operand keeps full latency, then max and mixed operands
      send(2, 8'h00, 8'h7F, 16'h0000, 1'b1, 1'b1);
      send(2, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b1);
      send(2, 8'hA5, 8'h3C, 16'h26AC, 1'b1, 1'b1);

      // Backpressure in DONE with a queued request behind it
      @(posedge clk);
      #1;
      ordy[2] = 1'b0;
      send(2, 8'h12, 8'h34, 16'h03A8, 1'b1, 1'b1);
      iv[2] = 1'b1;
      ia[2] = 8'h0B;
      ib[2] = 8'h0D;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid", 32'(ov8), 32'd1);
         chk("bp_out_z", 32'(oz8), 32'h03A8);
         chk("bp_in_ready", 32'(ir8), 32'd0);
      end
      ordy[2] = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_out_valid", 32'(ov8), 32'd0);
      chk("bp_release_in_ready", 32'(ir8), 32'd1);
      q.push_back('{k: 2, z: 16'h008F});
      @(posedge clk);
      #1;
      iv[2] = 1'b0;
      chk("queued_accept_in_ready", 32'(ir8), 32'd0);
      chk("queued_accept_busy", 32'(bz8), 32'd1);
      drain(40);

      // Reset in the middle of RUN discards the operation
      @(posedge clk);
      #1;
      send(2, 8'h55, 8'h66, 16'h0000, 1'b0, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(ov8), 32'd0);
      chk("abort_in_ready", 32'(ir8), 32'd1);
      chk("abort_out_z", 32'(oz8), 32'd0);
      chk("abort_busy", 32'(bz8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_result", 32'(ov8), 32'd0);
      send(2, 8'd2, 8'd3, 16'd6, 1'b1, 1'b1);
      drain(40);

      // WIDTH=4 exhaustive with random out_ready
      rnd_en = 1'b1;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            send(1, 8'(a), 8'(b), 16'(a * b), 1'b1, 1'b0);
         end
      end
      drain(2000);
      rnd_en = 1'b0;
      @(posedge clk);
      #1;
      ordy[1] = 1'b1;

      repeat (5) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
